// File: rtl/recirculador_param.sv
// Lane recirculator: routes qualified lane words back to the source
// until the link has been active long enough, then forwards them downstream.
// Optional macro RECIRC_CNT_EN adds the 16-bit recirc_cnt word counter.
module recirculador_param #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 2,
  parameter int ARM_CYCLES = 4
) (
  input  logic                   clk_2f,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] data_input,
  input  logic [LANES-1:0]       valid,
  input  logic                   active,
  output logic [LANES*WIDTH-1:0] demux_0,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] demux_1_probador,
  output logic [LANES-1:0]       valid_recirc,
  output logic [1:0]             state
`ifdef RECIRC_CNT_EN
  ,
  output logic [15:0]            recirc_cnt
`endif
);

  localparam logic [1:0] RECIRC  = 2'd0;
  localparam logic [1:0] ARMING  = 2'd1;
  localparam logic [1:0] FORWARD = 2'd2;

  localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES - 1);

  logic [1:0]             r_state;
  logic [7:0]             r_arm_cnt;
  logic [1:0]             w_state_nx;
  logic [7:0]             w_arm_nx;
  logic                   w_fwd;
  logic [LANES*WIDTH-1:0] w_masked;
  logic [LANES*WIDTH-1:0] r_demux_0;
  logic [LANES*WIDTH-1:0] r_demux_1;
  logic [LANES-1:0]       r_valid_out;
  logic [LANES-1:0]       r_valid_recirc;

  // Next-state and arm counter; state 3 falls back to RECIRC
  always_comb begin
    w_state_nx = RECIRC;
    w_arm_nx   = 8'd0;
    unique case (r_state)
      RECIRC: begin
        if (active) begin
          w_state_nx = ARMING;
          w_arm_nx   = 8'd1;
        end
      end
      ARMING: begin
        if (active) begin
          if (r_arm_cnt == ARM_LAST) begin
            w_state_nx = FORWARD;
          end else begin
            w_state_nx = ARMING;
            w_arm_nx   = r_arm_cnt + 8'd1;
          end
        end
      end
      FORWARD: begin
        if (active) begin
          w_state_nx = FORWARD;
        end
      end
      default: begin
        w_state_nx = RECIRC;
      end
    endcase
  end

  // State register; reset discards any partial arm count
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= RECIRC;
      r_arm_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_arm_cnt <= w_arm_nx;
    end
  end

  assign w_fwd = (r_state == FORWARD);

  // Per-lane qualification: unqualified lanes carry zero data
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid[i]) begin
        w_masked[i*WIDTH +: WIDTH] = data_input[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output registers; the unselected path is held at zero
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_demux_0      <= '0;
      r_valid_out    <= '0;
      r_demux_1      <= '0;
      r_valid_recirc <= '0;
    end else begin
      r_demux_0      <= w_fwd ? w_masked : '0;
      r_valid_out    <= w_fwd ? valid : '0;
      r_demux_1      <= w_fwd ? '0 : w_masked;
      r_valid_recirc <= w_fwd ? '0 : valid;
    end
  end

  assign demux_0          = r_demux_0;
  assign valid_out        = r_valid_out;
  assign demux_1_probador = r_demux_1;
  assign valid_recirc     = r_valid_recirc;
  assign state            = r_state;

`ifdef RECIRC_CNT_EN
  logic [15:0] r_cnt;
  logic [16:0] w_cnt_sum;

  // Add this cycle's valid lanes; the carry bit flags saturation
  always_comb begin
    w_cnt_sum = {1'b0, r_cnt};
    for (int i = 0; i < LANES; i++) begin
      w_cnt_sum = w_cnt_sum + 17'(valid[i]);
    end
  end

  // Saturating count of words seen outside FORWARD
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt <= 16'd0;
    end else if (!w_fwd) begin
      r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign recirc_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_recirculador_param.sv
// Directed bench for recirculador_param (default parameters).
// Cycle k means the interval just after rising edge k.
module tb_recirculador_param;

  logic        clk_2f;
  logic        reset_L;
  logic [63:0] data_input;
  logic [1:0]  valid;
  logic        active;
  logic [63:0] demux_0;
  logic [1:0]  valid_out;
  logic [63:0] demux_1_probador;
  logic [1:0]  valid_recirc;
  logic [1:0]  state;
`ifdef RECIRC_CNT_EN
  logic [15:0] recirc_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  recirculador_param #(
    .WIDTH(32),
    .LANES(2),
    .ARM_CYCLES(4)
  ) dut (
    .clk_2f(clk_2f),
    .reset_L(reset_L),
    .data_input(data_input),
    .valid(valid),
    .active(active),
    .demux_0(demux_0),
    .valid_out(valid_out),
    .demux_1_probador(demux_1_probador),
    .valid_recirc(valid_recirc),
    .state(state)
`ifdef RECIRC_CNT_EN
    ,
    .recirc_cnt(recirc_cnt)
`endif
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0]  st,
                         input logic [63:0] d0,
                         input logic [1:0]  v0,
                         input logic [63:0] d1,
                         input logic [1:0]  v1);
    chk({tag, ".state"}, 64'(state), 64'(st));
    chk({tag, ".demux_0"}, demux_0, d0);
    chk({tag, ".valid_out"}, 64'(valid_out), 64'(v0));
    chk({tag, ".demux_1"}, demux_1_probador, d1);
    chk({tag, ".valid_recirc"}, 64'(valid_recirc), 64'(v1));
  endtask

  initial begin
    reset_L    = 1'b1;
    active     = 1'b0;
    valid      = 2'b00;
    data_input = 64'd0;
    #2 reset_L = 1'b0;
    #1;
    chk_all("rst0", 2'd0, 64'd0, 2'b00, 64'd0, 2'b00);
    @(posedge clk_2f);
    #4 reset_L = 1'b1;

    // arming: state 1 for cycles 1-3, FORWARD at 4
    active = 1'b1;
    tick();
    chk("arm.c1", 64'(state), 64'd1);
    tick();
    chk("arm.c2", 64'(state), 64'd1);
    data_input = {32'h1111_2222, 32'h3333_4444};
    valid      = 2'b11;
    tick();
    chk_all("arm.c3", 2'd1, 64'd0, 2'b00,
            {32'h1111_2222, 32'h3333_4444}, 2'b11);
    data_input = 64'd0;
    valid      = 2'b00;
    tick();
    chk_all("arm.c4", 2'd2, 64'd0, 2'b00, 64'd0, 2'b00);
    data_input = {32'h0, 32'hA5A5_0001};
    valid      = 2'b01;
    tick();
    chk_all("arm.c5", 2'd2, {32'h0, 32'hA5A5_0001},
            2'b01, 64'd0, 2'b00);

    // forward drop: active falls in cycle t=5
    active     = 1'b0;
    data_input = {32'hCAFE_0002, 32'h5555_5555};
    valid      = 2'b10;
    tick();
    chk_all("drop.t1", 2'd0, {32'hCAFE_0002, 32'h0},
            2'b10, 64'd0, 2'b00);
    data_input = {32'h7777_7777, 32'h0BAD_0003};
    valid      = 2'b01;
    tick();
    chk_all("drop.t2", 2'd0, 64'd0, 2'b00,
            {32'h0, 32'h0BAD_0003}, 2'b01);

    // per-lane qualification in RECIRC
    data_input = {32'hDEAD_BEEF, 32'h1234_5678};
    valid      = 2'b10;
    tick();
    chk_all("lane", 2'd0, 64'd0, 2'b00,
            {32'hDEAD_BEEF, 32'h0}, 2'b10);

    // aborted arm: states 0,1,1,1,0,1 and no forward valid
    valid      = 2'b11;
    data_input = {32'hAAAA_0000, 32'hBBBB_0000};
    active     = 1'b1;
    chk("abort.c0", 64'(state), 64'd0);
    tick();
    chk("abort.c1", 64'(state), 64'd1);
    chk("abort.v1", 64'(valid_out), 64'd0);
    tick();
    chk("abort.c2", 64'(state), 64'd1);
    tick();
    chk("abort.c3", 64'(state), 64'd1);
    chk("abort.v3", 64'(valid_out), 64'd0);
    active = 1'b0;
    tick();
    chk("abort.c4", 64'(state), 64'd0);
    chk("abort.v4", 64'(valid_out), 64'd0);
    active = 1'b1;
    tick();
    chk("abort.c5", 64'(state), 64'd1);
    chk("abort.v5", 64'(valid_out), 64'd0);
    chk("abort.r5", 64'(valid_recirc), 64'd3);

    // re-arm from scratch, then drop active right at FORWARD entry
    active = 1'b0;
    valid  = 2'b00;
    tick();
    chk("tog.idle", 64'(state), 64'd0);
    active = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("tog.arm", 64'(state), 64'd1);
    tick();
    chk("tog.entry", 64'(state), 64'd2);
    active     = 1'b0;
    data_input = {32'h0102_0304, 32'h0506_0708};
    valid      = 2'b11;
    tick();
    chk_all("tog.exit", 2'd0, {32'h0102_0304, 32'h0506_0708},
            2'b11, 64'd0, 2'b00);
    tick();
    chk_all("tog.after", 2'd0, 64'd0, 2'b00,
            {32'h0102_0304, 32'h0506_0708}, 2'b11);

    // asynchronous reset mid-ARMING discards the arm count
    active = 1'b1;
    tick();
    tick();
    chk("mid.pre", 64'(valid_recirc), 64'd3);
    #1 reset_L = 1'b0;
    #1;
    chk_all("mid.rst", 2'd0, 64'd0, 2'b00, 64'd0, 2'b00);
    #1 reset_L = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("mid.c3", 64'(state), 64'd1);
    tick();
    chk("mid.c4", 64'(state), 64'd2);

`ifdef RECIRC_CNT_EN
    active = 1'b0;
    valid  = 2'b00;
    #1 reset_L = 1'b0;
    #1;
    chk("cnt.rst", 64'(recirc_cnt), 64'd0);
    #1 reset_L = 1'b1;
    valid = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    chk("cnt.six", 64'(recirc_cnt), 64'd6);
    valid = 2'b01;
    tick();
    chk("cnt.seven", 64'(recirc_cnt), 64'd7);
    active = 1'b1;
    valid  = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    valid = 2'b11;
    tick();
    tick();
    chk("cnt.fwd", 64'(recirc_cnt), 64'd7);
    active = 1'b0;
    valid  = 2'b00;
    tick();
    valid = 2'b11;
    for (int i = 0; i < 40000; i++) tick();
    chk("cnt.sat", 64'(recirc_cnt), 64'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("cnt.hold", 64'(recirc_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
